// File: rtl/comparator_pkg.sv
// Shared types and constants for the 4-bit comparator checker.
package comparator_pkg;

  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Flag vector ordered {lt, eq, gt}.
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } flags_t;

endpackage

// File: rtl/comparator_4_bit_model.sv
// Golden unsigned 4-bit comparator producing the expected {lt, eq, gt} flags.
module comparator_4_bit_model
  import comparator_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output flags_t            expected_c
);

  always_comb begin
    expected_c    = '0;
    expected_c.lt = (a < b);
    expected_c.eq = (a == b);
    expected_c.gt = (a > b);
  end

endmodule

// File: rtl/comparator_4_bit_checker.sv
// Runs NUM_SAMPLES comparator samples against a golden model, counting mismatches
// and capturing the operands of the first one.
module comparator_4_bit_checker
  import comparator_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 10,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              Clock_In,
  input  logic              Reset_In,
  input  logic              Start_In,
  input  logic              Sample_Valid_In,
  input  logic [DATA_W-1:0] Data_A_In,
  input  logic [DATA_W-1:0] Data_B_In,
  input  logic              A_Less_Than_B_In,
  input  logic              A_Equal_To_B_In,
  input  logic              A_Greater_Than_B_In,
  output logic              Busy_Out,
  output logic              Done_Out,
  output logic              Pass_Out,
  output logic [CNT_W-1:0]  Sample_Count_Out,
  output logic [CNT_W-1:0]  Error_Count_Out,
  output logic [DATA_W-1:0] First_Error_A_Out,
  output logic [DATA_W-1:0] First_Error_B_Out,
  output logic              First_Error_Valid_Out
);

  state_e           state;
  state_e           state_nxt;
  flags_t           expected;
  flags_t           observed;
  logic             start_run;
  logic             accept;
  logic             mismatch;
  logic             last;
  logic [CNT_W-1:0] sample_cnt_nxt;
  logic [CNT_W-1:0] error_cnt_nxt;

  comparator_4_bit_model u_model (
    .a          (Data_A_In),
    .b          (Data_B_In),
    .expected_c (expected)
  );

  assign observed = {A_Less_Than_B_In, A_Equal_To_B_In, A_Greater_Than_B_In};

  // Datapath controls; samples count only in RUN, starts only outside RUN.
  always_comb begin
    start_run      = Start_In && (state != ST_RUN);
    accept         = Sample_Valid_In && (state == ST_RUN);
    mismatch       = (observed != expected);
    sample_cnt_nxt = Sample_Count_Out + CNT_W'(1);
    error_cnt_nxt  = Error_Count_Out;
    if (mismatch && (Error_Count_Out != '1)) begin
      error_cnt_nxt = Error_Count_Out + CNT_W'(1);
    end
    last = (sample_cnt_nxt == CNT_W'(NUM_SAMPLES));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (Start_In) state_nxt = ST_RUN;
      ST_RUN:  if (Sample_Valid_In && last) state_nxt = ST_DONE;
      ST_DONE: if (Start_In) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs; status flags follow the next state so Done and the
  // final counter update land in the same cycle.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      Busy_Out              <= 1'b0;
      Done_Out              <= 1'b0;
      Pass_Out              <= 1'b0;
      Sample_Count_Out      <= '0;
      Error_Count_Out       <= '0;
      First_Error_A_Out     <= '0;
      First_Error_B_Out     <= '0;
      First_Error_Valid_Out <= 1'b0;
    end else begin
      Busy_Out <= (state_nxt == ST_RUN);
      Done_Out <= (state_nxt == ST_DONE);
      if (start_run) begin
        Pass_Out              <= 1'b0;
        Sample_Count_Out      <= '0;
        Error_Count_Out       <= '0;
        First_Error_A_Out     <= '0;
        First_Error_B_Out     <= '0;
        First_Error_Valid_Out <= 1'b0;
      end else if (accept) begin
        Sample_Count_Out <= sample_cnt_nxt;
        Error_Count_Out  <= error_cnt_nxt;
        if (mismatch && !First_Error_Valid_Out) begin
          First_Error_A_Out     <= Data_A_In;
          First_Error_B_Out     <= Data_B_In;
          First_Error_Valid_Out <= 1'b1;
        end
        if (last) begin
          Pass_Out <= (error_cnt_nxt == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_comparator_4_bit_checker.sv
// Directed + randomized bench for comparator_4_bit_checker against a behavioural model.
module tb_comparator_4_bit_checker;

  localparam int unsigned N  = 10;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          valid = 1'b0;
  logic [3:0]    a = '0;
  logic [3:0]    b = '0;
  logic          lt = 1'b0;
  logic          eq = 1'b0;
  logic          gt = 1'b0;
  logic          busy, done, pass, fev;
  logic [CW-1:0] scnt, ecnt;
  logic [3:0]    fa, fb;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_state = 0;  // 0 idle, 1 run, 2 done
  int m_cnt = 0, m_err = 0, m_fa = 0, m_fb = 0;
  bit m_fev = 0, m_done = 0, m_pass = 0, m_known = 0;

  always #5 clk = ~clk;

  comparator_4_bit_checker #(.NUM_SAMPLES(N), .CNT_W(CW)) dut (
    .Clock_In              (clk),
    .Reset_In              (rst),
    .Start_In              (start),
    .Sample_Valid_In       (valid),
    .Data_A_In             (a),
    .Data_B_In             (b),
    .A_Less_Than_B_In      (lt),
    .A_Equal_To_B_In       (eq),
    .A_Greater_Than_B_In   (gt),
    .Busy_Out              (busy),
    .Done_Out              (done),
    .Pass_Out              (pass),
    .Sample_Count_Out      (scnt),
    .Error_Count_Out       (ecnt),
    .First_Error_A_Out     (fa),
    .First_Error_B_Out     (fb),
    .First_Error_Valid_Out (fev)
  );

  function automatic logic [2:0] expf(input int unsigned x, input int unsigned y);
    return {x < y, x == y, x > y};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then check every output.
  task automatic cyc(input bit r, input bit s, input bit v,
                     input logic [3:0] xa, input logic [3:0] xb, input logic [2:0] fl);
    rst = r; start = s; valid = v; a = xa; b = xb;
    {lt, eq, gt} = fl;
    if (r) begin
      m_state = 0; m_cnt = 0; m_err = 0; m_fa = 0; m_fb = 0;
      m_fev = 0; m_done = 0; m_pass = 0; m_known = 1;
    end else if (m_state != 1) begin
      if (s) begin
        m_state = 1; m_cnt = 0; m_err = 0; m_fev = 0;
        m_done = 0; m_pass = 0; m_known = 0;
      end
    end else if (v) begin
      m_cnt++;
      if (fl != expf(xa, xb)) begin
        if (m_err < 255) m_err++;
        if (!m_fev) begin
          m_fev = 1; m_fa = xa; m_fb = xb; m_known = 1;
        end
      end
      if (m_cnt == N) begin
        m_state = 2; m_done = 1; m_pass = (m_err == 0);
      end
    end
    @(posedge clk);
    #1;
    chk("busy", busy, m_state == 1);
    chk("done", done, m_done);
    chk("pass", pass, m_pass);
    chk("sample_count", scnt, m_cnt);
    chk("error_count", ecnt, m_err);
    chk("first_err_valid", fev, m_fev);
    if (m_known) begin
      chk("first_err_a", fa, m_fa);
      chk("first_err_b", fb, m_fb);
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 4'($urandom), 4'($urandom), 3'($urandom));
  endtask

  task automatic good(input logic [3:0] xa, input logic [3:0] xb);
    cyc(0, 0, 1, xa, xb, expf(xa, xb));
  endtask

  task automatic good_rand();
    if ($urandom_range(0, 3) == 0) idle();
    good(4'($urandom), 4'($urandom));
  endtask

  task automatic wrong_rand();
    logic [3:0] xa, xb;
    xa = 4'($urandom);
    xb = 4'($urandom);
    cyc(0, 0, 1, xa, xb, expf(xa, xb) ^ 3'($urandom_range(1, 7)));
  endtask

  task automatic go();
    cyc(0, 1, 0, 4'd0, 4'd0, 3'b000);
  endtask

  initial begin
    // Reset state, then valid pulse in IDLE is ignored
    cyc(1, 0, 0, 4'd0, 4'd0, 3'b000);
    cyc(1, 0, 0, 4'd0, 4'd0, 3'b000);
    cyc(0, 0, 1, 4'd5, 4'd6, 3'b001);
    chk("idle_valid_ignored", scnt, 0);

    // Clean run
    go();
    good(4'd3, 4'd5); good(4'd9, 4'd9); good(4'd12, 4'd1);
    for (int i = 3; i < 10; i++) good_rand();
    chk("run1_done", done, 1);
    chk("run1_pass", pass, 1);
    chk("run1_count", scnt, 10);
    chk("run1_errors", ecnt, 0);

    // Back-to-back restart on the Done cycle; errors at samples 4 and 8,
    // plus a Start pulse in RUN that must be ignored
    go();
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) cyc(0, 0, 1, 4'd7, 4'd2, 3'b100);
      else if (i == 8) wrong_rand();
      else if (i == 6) cyc(0, 1, 1, 4'd1, 4'd8, 3'b100);
      else good_rand();
      if (i == 5) begin
        cyc(0, 1, 0, 4'd0, 4'd0, 3'b000);
        chk("start_in_run_busy", busy, 1);
        chk("start_in_run_count", scnt, 5);
      end
    end
    chk("run2_errors", ecnt, 2);
    chk("run2_first_a", fa, 7);
    chk("run2_first_b", fb, 2);
    chk("run2_pass", pass, 0);

    // Valid in DONE is ignored
    wrong_rand();
    chk("done_valid_ignored", scnt, 10);
    chk("done_valid_errors", ecnt, 2);

    // Non-one-hot flags on equal operands
    go();
    cyc(0, 0, 1, 4'd4, 4'd4, 3'b110);
    chk("nonhot_error", ecnt, 1);
    for (int i = 1; i < 10; i++) good_rand();

    // Only the final sample is wrong
    go();
    for (int i = 1; i < 10; i++) good_rand();
    chk("last_pre_done", done, 0);
    chk("last_pre_errors", ecnt, 0);
    wrong_rand();
    chk("last_done", done, 1);
    chk("last_errors", ecnt, 1);
    chk("last_pass", pass, 0);

    // Reset mid-run with Start and Valid also high, then a fresh run
    go();
    for (int i = 0; i < 5; i++) good_rand();
    cyc(1, 1, 1, 4'd2, 4'd3, 3'b100);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", scnt, 0);
    chk("midrst_first_valid", fev, 0);
    go();
    good(4'd15, 4'd0);
    chk("fresh_count", scnt, 1);
    for (int i = 1; i < 10; i++) good_rand();

    // Fully random flags
    for (int r = 0; r < 4; r++) begin
      go();
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 3) == 0) idle();
        cyc(0, 0, 1, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
